mul_cell_sequencer: RTL and testbench

Multi-cycle controller that time-shares one registered 16x16 unsigned multiplier cell to produce Nios II-style 32x32 multiply results (low word, or high word with unsigned/signed variants). It sits between the execute-stage operand source and a single external multiplier primitive: it splits the operands into 16-bit halves, issues the partial products, accumulates them into a 64-bit sum, applies signed correction and returns a 32-bit result over a valid/ready handshake.

---
 rtl/mul_cell_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_mul_cell_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_cell_sequencer.sv
// -----------------------------------------------------------------------------
// mul_cell_sequencer
//
// Builds Nios II-style 32x32 multiply results (low word, or high word with
// unsigned / signed-unsigned / signed variants) from a single external
// registered 16x16 unsigned multiplier. The 32-bit operands are split into
// 16-bit halves and one partial product is issued per cycle. The products are
// summed into a 64-bit accumulator, a signed correction is applied to the high
// word, and the result is returned over a valid/ready handshake.
//
// Parameters
//   MUL_LAT     register stages inside the external multiplier (1..3)
//
// Ports
//   clk         single clock, all state on rising edge
//   reset_n     asynchronous active-low reset
//   req_valid   request present
//   req_ready   block can accept a request (IDLE only)
//   req_op      00 mul, 01 mulxuu, 10 mulxsu, 11 mulxss
//   req_src1/2  operands a, b (only sampled in the acceptance cycle)
//   rsp_valid   result valid
//   rsp_ready   consumer accepts result
//   rsp_result  32-bit result word, held stable while rsp_valid is high
//   mul_a/mul_b 16-bit operand halves to the multiplier
//   mul_en      multiplier pipeline enable
//   mul_p       32-bit unsigned product from the multiplier
// -----------------------------------------------------------------------------
module mul_cell_sequencer #(
    parameter int MUL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_src1,
    input  logic [31:0] req_src2,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [15:0] mul_a,
    output logic [15:0] mul_b,
    output logic        mul_en,
    input  logic [31:0] mul_p
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIX, S_DONE} state_t;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b11;

    state_t      r_state, w_next_state;
    logic [1:0]  r_op;
    logic [1:0]  r_idx, w_next_idx, w_last_idx;
    logic [31:0] r_a, r_b, w_a_src, w_b_src;
    logic [63:0] r_acc, w_pp;
    logic [31:0] r_result, w_result, w_hi;

    // Tag pipeline: follows each issued product through the multiplier so the
    // returning product is aligned by the index it was issued with.
    logic [MUL_LAT-1:0] r_tag_v;
    logic [1:0]         r_tag [MUL_LAT];

    logic        w_accept, w_last_prod;
    logic        r_req_ready, r_rsp_valid, r_mul_en;
    logic [15:0] r_mul_a, r_mul_b;
    logic        w_req_ready, w_rsp_valid, w_mul_en;
    logic [15:0] w_mul_a, w_mul_b;

    assign w_accept    = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_last_idx  = (r_op == OP_MUL) ? 2'd2 : 2'd3;
    assign w_last_prod = r_tag_v[MUL_LAT-1] && (r_tag[MUL_LAT-1] == w_last_idx);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge value of every other register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    // --------------------------------------------------------------- next state
    // NOTE: every signal written here is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next_state = S_ISSUE;
                    w_next_idx   = 2'd0;
                end
            end
            S_ISSUE: begin
                if (r_idx == w_last_idx) w_next_state = S_DRAIN;
                else                     w_next_idx   = r_idx + 2'd1;
            end
            S_DRAIN:  if (w_last_prod) w_next_state = S_FIX;
            S_FIX:    w_next_state = S_DONE;
            S_DONE:   if (rsp_ready) w_next_state = S_IDLE;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------ outputs
    // Outputs are registered from the next state so they are all 0 in reset and
    // req_ready only rises after the first edge following reset release.
    always_comb begin
        w_a_src     = w_accept ? req_src1 : r_a;
        w_b_src     = w_accept ? req_src2 : r_b;
        w_req_ready = (w_next_state == S_IDLE);
        w_rsp_valid = (w_next_state == S_DONE);
        w_mul_en    = (w_next_state == S_ISSUE) || (w_next_state == S_DRAIN);
        w_mul_a     = 16'd0;
        w_mul_b     = 16'd0;
        if (w_next_state == S_ISSUE) begin
            // Index bit 1 selects the half of a, bit 0 the half of b: LL, LH, HL, HH.
            w_mul_a = w_next_idx[1] ? w_a_src[31:16] : w_a_src[15:0];
            w_mul_b = w_next_idx[0] ? w_b_src[31:16] : w_b_src[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_mul_en    <= 1'b0;
            r_mul_a     <= 16'd0;
            r_mul_b     <= 16'd0;
        end else begin
            r_req_ready <= w_req_ready;
            r_rsp_valid <= w_rsp_valid;
            r_mul_en    <= w_mul_en;
            r_mul_a     <= w_mul_a;
            r_mul_b     <= w_mul_b;
        end
    end

    assign req_ready  = r_req_ready;
    assign rsp_valid  = r_rsp_valid;
    assign mul_en     = r_mul_en;
    assign mul_a      = r_mul_a;
    assign mul_b      = r_mul_b;
    assign rsp_result = r_result;

    // ---------------------------------------------------------------- datapath
    always_comb begin
        case (r_tag[MUL_LAT-1])
            2'd0:    w_pp = {32'd0, mul_p};
            2'd1,
            2'd2:    w_pp = {16'd0, mul_p, 16'd0};
            default: w_pp = {mul_p, 32'd0};
        endcase
    end

    // High word of the unsigned product minus the two's-complement corrections.
    always_comb begin
        w_hi = r_acc[63:32];
        if (r_op[1] && r_a[31])                 w_hi = w_hi - r_b;
        if ((r_op == OP_MULXSS) && r_b[31])     w_hi = w_hi - r_a;
        w_result = (r_op == OP_MUL) ? r_acc[31:0] : w_hi;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_op     <= 2'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_acc    <= 64'd0;
            r_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_op  <= req_op;
                r_a   <= req_src1;
                r_b   <= req_src2;
                r_acc <= 64'd0;
            end else if (r_tag_v[MUL_LAT-1]) begin
                r_acc <= r_acc + w_pp;
            end
            if (r_state == S_FIX) r_result <= w_result;
        end
    end

    // NOTE: the tag array is reset on purpose; a stale valid tag after reset
    // would accumulate whatever the multiplier still presents on mul_p.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tag_v <= '0;
            for (int i = 0; i < MUL_LAT; i++) r_tag[i] <= 2'd0;
        end else begin
            r_tag_v[0] <= (r_state == S_ISSUE);
            r_tag[0]   <= r_idx;
            for (int i = 1; i < MUL_LAT; i++) begin
                r_tag_v[i] <= r_tag_v[i-1];
                r_tag[i]   <= r_tag[i-1];
            end
        end
    end

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mul_cell_sequencer
//
// Drives mul_cell_sequencer (MUL_LAT=2) with a behavioural pipelined 16x16
// multiplier. Expected results are pushed to a scoreboard queue at request
// acceptance and compared when the response handshake happens; response
// latency and the number of mul_en cycles are checked against the acceptance
// cycle. Directed sequences cover backpressure and reset mid-operation,
// followed by random traffic against a 64-bit reference model.
// -----------------------------------------------------------------------------
module tb_mul_cell_sequencer;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid, req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_src1, req_src2;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_result;
    logic [15:0] mul_a, mul_b;
    logic        mul_en;
    logic [31:0] mul_p;

    always #5 clk = ~clk;

    mul_cell_sequencer #(.MUL_LAT(LAT)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_src1   (req_src1),
        .req_src2   (req_src2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_en     (mul_en),
        .mul_p      (mul_p)
    );

    // External multiplier: LAT register stages, advancing while mul_en is high.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        if (mul_en) begin
            pipe[0] <= 32'(mul_a) * 32'(mul_b);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mul_p = pipe[LAT-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        logic [31:0] exp;
        int          t;
        int          n;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    function automatic int n_issue(input logic [1:0] op);
        return (op == 2'b00) ? 3 : 4;
    endfunction

    // Reference: full 64-bit product of sign/zero-extended operands.
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = {{32{a[31] & op[1]}}, a};
        xb = {{32{b[31] & (op == 2'b11)}}, b};
        p  = xa * xb;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // ------------------------------------------------------------- monitor
    logic prev_valid = 1'b0;
    int   en_cnt = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_valid <= 1'b0;
            en_cnt     <= 0;
        end else begin
            if (rsp_valid && !prev_valid) begin
                if (sbq.size() == 0) begin
                    check("unexpected_rsp", 32'(sbq.size()), 32'd1);
                end else begin
                    check("latency", 32'(cyc), 32'(sbq[0].t + sbq[0].n + LAT + 2));
                    check("mul_en_cycles", 32'(en_cnt), 32'(sbq[0].n + LAT));
                    check("result_at_valid", rsp_result, sbq[0].exp);
                end
                en_cnt <= 0;
            end else if (mul_en) begin
                en_cnt <= en_cnt + 1;
            end
            if (rsp_valid && rsp_ready && sbq.size() != 0) begin
                check("result", rsp_result, sbq[0].exp);
                void'(sbq.pop_front());
            end
            prev_valid <= rsp_valid;
        end
    end

    // ------------------------------------------------------------- driver
    task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, output int t_acc);
        int guard = 0;
        bit ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = op;
        req_src1  = a;
        req_src2  = b;
        t_acc     = -1;
        while (!ok && guard < 200) begin
            @(negedge clk);
            if (req_ready) ok = 1'b1;
            else guard++;
        end
        if (!ok) begin
            check("accept_timeout", 32'(ok), 32'd1);
        end else begin
            sbq.push_back('{exp, cyc, n_issue(op)});
            t_acc = cyc;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_src1  = $urandom;
        req_src2  = $urandom;
    endtask

    task automatic wait_done();
        int g = 0;
        while (sbq.size() != 0 && g < 500) begin
            @(negedge clk);
            g++;
        end
        check("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // ------------------------------------------------------------- stimulus
    initial begin
        int t, t_prev, n_prev, g;
        logic [1:0]  op;
        logic [31:0] a, b;

        vecs[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 32'h000B_000F};
        vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[2] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};
        vecs[3] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
        vecs[4] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[5] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001};
        vecs[6] = '{2'b00, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[7] = '{2'b11, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[8] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[9] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};

        req_valid = 1'b0;
        req_op    = 2'b00;
        req_src1  = 32'd0;
        req_src2  = 32'd0;
        rsp_ready = 1'b1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_mul_en", 32'(mul_en), 32'd0);
        check("rst_mul_ab", {mul_a, mul_b}, 32'd0);
        check("rst_result", rsp_result, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_before_edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("ready_after_release", 32'(req_ready), 32'd1);

        // Table vectors back to back; acceptance spacing gives throughput.
        t_prev = -1;
        n_prev = 0;
        for (int i = 0; i < 10; i++) begin
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, t);
            if (i > 0) check("throughput", 32'(t - t_prev), 32'(n_prev + LAT + 3));
            t_prev = t;
            n_prev = n_issue(vecs[i].op);
        end
        wait_done();

        // Backpressure with a pending request held during DONE.
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, t);
        g = 0;
        while (!rsp_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("bp_wait_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_op    = 2'b00;
        req_src1  = 32'h0000_0003;
        req_src2  = 32'h0000_0005;
        repeat (5) begin
            @(negedge clk);
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_result", rsp_result, 32'hFFFF_FFFE);
            check("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("accept_after_hs", 32'(req_ready), 32'd1);
        sbq.push_back('{32'h0000_000F, cyc, 3});
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_src1  = $urandom;
        req_src2  = $urandom;
        wait_done();

        // Reset pulsed in the second ISSUE cycle.
        send(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, ref_mul(2'b11, 32'h1234_5678, 32'h9ABC_DEF0), t);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        sbq.delete();
        check("mid_rst_mul_en", 32'(mul_en), 32'd0);
        check("mid_rst_mul_ab", {mul_a, mul_b}, 32'd0);
        check("mid_rst_req_ready", 32'(req_ready), 32'd0);
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_result", rsp_result, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_rsp_after_rst", 32'(rsp_valid), 32'd0);
        send(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, t);
        wait_done();

        // Random traffic against the reference model.
        for (int i = 0; i < 200; i++) begin
            op = 2'($urandom_range(0, 3));
            a  = pick();
            b  = pick();
            send(op, a, b, ref_mul(op, a, b), t);
        end
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
